// File: rtl/unified_mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-outstanding memory port.
// Define ARB_TIMEOUT_EN to enable a watchdog that aborts a BUSY transaction after TIMEOUT cycles.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 4,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,

    output logic              stall_if,
    output logic              stall_mem,
    output logic              arb_err
);

    localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 2);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } state_t;

    state_t              state, state_next;
    logic [STREAK_W-1:0] streak, streak_next;
    logic                grant_dm, grant_if;

    logic                mem_req_next, mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_next;
    logic                if_ack_next, dm_ack_next;
    logic [DATA_W-1:0]   if_rdata_next, dm_rdata_next;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd, wd_next;
    logic            arb_err_next;
`else
    assign arb_err = 1'b0;
`endif

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

    always_comb begin
        state_next     = state;
        streak_next    = streak;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        if_ack_next    = 1'b0;
        dm_ack_next    = 1'b0;
        if_rdata_next  = if_rdata;
        dm_rdata_next  = dm_rdata;
`ifdef ARB_TIMEOUT_EN
        wd_next        = wd;
        arb_err_next   = 1'b0;
`endif
        // streak never exceeds STREAK_MAX, so these two grants are mutually exclusive
        grant_dm = dm_req && (!if_req || (streak < STREAK_MAX));
        grant_if = if_req && (!dm_req || (streak == STREAK_MAX));

        case (state)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                wd_next = '0;
`endif
                if (grant_dm) begin
                    state_next     = DM_BUSY;
                    mem_req_next   = 1'b1;
                    mem_we_next    = dm_we;
                    mem_addr_next  = dm_addr;
                    mem_wdata_next = dm_wdata;
                    if (if_req && (streak < STREAK_MAX)) begin
                        streak_next = streak + 1'b1;
                    end
                end else if (grant_if) begin
                    state_next    = IF_BUSY;
                    mem_req_next  = 1'b1;
                    mem_we_next   = 1'b0;
                    mem_addr_next = if_addr;
                    streak_next   = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ack) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    if (state == IF_BUSY) begin
                        if_ack_next   = 1'b1;
                        if_rdata_next = mem_rdata;
                    end else begin
                        dm_ack_next = 1'b1;
                        if (!mem_we) begin
                            dm_rdata_next = mem_rdata;
                        end
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd == WD_LAST) begin
                    // Abort: owner sees its ack alongside arb_err, read data left untouched
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    arb_err_next = 1'b1;
                    if (state == IF_BUSY) begin
                        if_ack_next = 1'b1;
                    end else begin
                        dm_ack_next = 1'b1;
                    end
                end else begin
                    wd_next = wd + 1'b1;
                end
`endif
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
                mem_we_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            streak    <= streak_next;
            mem_req   <= mem_req_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            if_ack    <= if_ack_next;
            dm_ack    <= dm_ack_next;
            if_rdata  <= if_rdata_next;
            dm_rdata  <= dm_rdata_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd      <= '0;
            arb_err <= 1'b0;
        end else begin
            wd      <= wd_next;
            arb_err <= arb_err_next;
        end
    end
`endif

endmodule
